rr_output_arbiter: RTL and testbench

//   Consumer side of the NOC round-robin priority register: arbitrates NUM_PORTS input

---
 rtl/rr_pkg.sv | 19 +
 rtl/rr_pick.sv | 52 +++++
 rtl/rr_output_arbiter.sv | 113 +++++++++++
 tb/tb_rr_output_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
// Shared types and constants for the round-robin output arbiter.
// The arbiter consumes the one-hot priority vector produced by rr_register.
package rr_pkg;

    localparam int RR_NUM_PORTS = 4;

    typedef enum logic {
        RR_IDLE = 1'b0,
        RR_BUSY = 1'b1
    } rr_state_t;

    typedef logic [RR_NUM_PORTS-1:0] rr_vec_t;

    // Odd parity over a port vector, used to guard the registered grant.
    function automatic logic rr_parity(input logic [RR_NUM_PORTS-1:0] vec);
        rr_parity = ^vec;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-scan winner selection.
// Scans from the priority position upward with wrap-around and returns the first valid request.
module rr_pick
    import rr_pkg::*;
#(
    parameter int NUM_PORTS = RR_NUM_PORTS
) (
    input  logic [NUM_PORTS-1:0] priority_vec,
    input  logic [NUM_PORTS-1:0] request_vec,
    output logic [NUM_PORTS-1:0] winner,
    output logic                 any_valid
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [IDX_W:0] PORTS_L = (IDX_W+1)'(NUM_PORTS);

    logic [IDX_W-1:0]     start_s;
    logic [IDX_W:0]       sum_s;
    logic [IDX_W-1:0]     idx_s;
    logic                 hit_s;
    logic                 found_s;
    logic [NUM_PORTS-1:0] winner_s;

    // Start index: lowest set priority bit (covers one-hot and malformed vectors), 0 when empty.
    always_comb begin
        start_s = {IDX_W{1'b0}};
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            start_s = priority_vec[i] ? IDX_W'(i) : start_s;
        end
    end

    // Walk the ports starting at start_s; the first valid request wins.
    always_comb begin
        sum_s    = {(IDX_W+1){1'b0}};
        idx_s    = {IDX_W{1'b0}};
        hit_s    = 1'b0;
        found_s  = 1'b0;
        winner_s = {NUM_PORTS{1'b0}};
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum_s = {1'b0, start_s} + (IDX_W+1)'(k);
            sum_s = (sum_s >= PORTS_L) ? (sum_s - PORTS_L) : sum_s;
            idx_s = sum_s[IDX_W-1:0];
            hit_s = ~found_s & request_vec[idx_s];
            winner_s[idx_s] = winner_s[idx_s] | hit_s;
            found_s = found_s | hit_s;
        end
    end

    assign winner    = winner_s;
    assign any_valid = |request_vec;

endmodule

// File: rtl/rr_output_arbiter.sv
// Wormhole output arbiter: grants one input port per packet and forwards its flits.
// Pulses change_order_o on each tail transfer so the upstream priority register rotates.
module rr_output_arbiter
    import rr_pkg::*;
#(
    parameter int NUM_PORTS  = RR_NUM_PORTS,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            priority_order_i,
    input  logic [NUM_PORTS-1:0]            req_valid_i,
    input  logic [NUM_PORTS-1:0]            req_tail_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_PORTS-1:0]            req_ready_o,
    output logic                            out_valid_o,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    output logic                            out_tail_o,
    input  logic                            out_ready_i,
    output logic [NUM_PORTS-1:0]            grant_o,
    output logic                            change_order_o
);

    rr_state_t            state_r;
    logic [NUM_PORTS-1:0] grant_r;

    logic [NUM_PORTS-1:0]  winner_s;
    logic                  any_valid_s;
    logic                  busy_s;
    logic                  valid_sel_s;
    logic                  tail_sel_s;
    logic [DATA_WIDTH-1:0] data_sel_s;
    logic                  out_valid_s;
    logic                  transfer_s;
    logic                  tail_xfer_s;
    logic [NUM_PORTS-1:0]  ready_s;
    logic [DATA_WIDTH-1:0] out_data_s;
    logic                  out_tail_s;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .priority_vec (priority_order_i),
        .request_vec  (req_valid_i),
        .winner       (winner_s),
        .any_valid    (any_valid_s)
    );

    // AND-OR mux of the granted port; grant_r is one-hot or zero.
    always_comb begin
        valid_sel_s = 1'b0;
        tail_sel_s  = 1'b0;
        data_sel_s  = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < NUM_PORTS; k++) begin
            valid_sel_s = valid_sel_s | (grant_r[k] & req_valid_i[k]);
            tail_sel_s  = tail_sel_s  | (grant_r[k] & req_tail_i[k]);
            data_sel_s  = data_sel_s  |
                          (req_data_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_r[k]}});
        end
    end

    // Handshake decode; everything is forced to zero outside BUSY, including during reset.
    always_comb begin
        busy_s      = (state_r == RR_BUSY);
        out_valid_s = busy_s & valid_sel_s;
        out_tail_s  = busy_s & tail_sel_s;
        out_data_s  = out_valid_s ? data_sel_s : {DATA_WIDTH{1'b0}};
        ready_s     = busy_s ? (grant_r & {NUM_PORTS{out_ready_i}}) : {NUM_PORTS{1'b0}};
        transfer_s  = out_valid_s & out_ready_i;
        tail_xfer_s = transfer_s & out_tail_s;
    end

    // Arbitration FSM: one cycle to pick in IDLE, grant held until the tail leaves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RR_IDLE;
            grant_r <= {NUM_PORTS{1'b0}};
        end else begin
            case (state_r)
                RR_IDLE: begin
                    if (any_valid_s) begin
                        state_r <= RR_BUSY;
                        grant_r <= winner_s;
                    end else begin
                        state_r <= RR_IDLE;
                        grant_r <= {NUM_PORTS{1'b0}};
                    end
                end
                RR_BUSY: begin
                    if (tail_xfer_s) begin
                        state_r <= RR_IDLE;
                        grant_r <= {NUM_PORTS{1'b0}};
                    end else begin
                        state_r <= RR_BUSY;
                        grant_r <= grant_r;
                    end
                end
                default: begin
                    state_r <= RR_IDLE;
                    grant_r <= {NUM_PORTS{1'b0}};
                end
            endcase
        end
    end

    assign grant_o        = grant_r;
    assign req_ready_o    = ready_s;
    assign out_valid_o    = out_valid_s;
    assign out_data_o     = out_data_s;
    assign out_tail_o     = out_tail_s;
    assign change_order_o = tail_xfer_s;

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Directed bench for rr_output_arbiter: per-cycle vector table plus hand-written
// sequences for reset mid-packet and closed-loop rotation.
module tb_rr_output_arbiter;
    import rr_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk;
    logic            reset;
    rr_vec_t         priority_order;
    rr_vec_t         req_valid;
    rr_vec_t         req_tail;
    logic [N*DW-1:0] req_data;
    rr_vec_t         req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_tail;
    logic            out_ready;
    rr_vec_t         grant;
    logic            change_order;

    int total;
    int bad;

    rr_output_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .priority_order_i (priority_order),
        .req_valid_i      (req_valid),
        .req_tail_i       (req_tail),
        .req_data_i       (req_data),
        .req_ready_o      (req_ready),
        .out_valid_o      (out_valid),
        .out_data_o       (out_data),
        .out_tail_o       (out_tail),
        .out_ready_i      (out_ready),
        .grant_o          (grant),
        .change_order_o   (change_order)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        rr_vec_t prio;
        rr_vec_t vld;
        rr_vec_t tail;
        logic    ordy;
        rr_vec_t e_gnt;
        logic    e_ov;
        rr_vec_t e_rdy;
        logic    e_co;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    function automatic int idx_of(input rr_vec_t g);
        int r;
        r = 0;
        for (int k = 0; k < N; k++) if (g[k]) r = k;
        return r;
    endfunction

    function automatic logic [DW-1:0] flit(input int row, input int port);
        return {8'(row), 8'(port), 16'hBEEF};
    endfunction

    task automatic drive_data(input int row);
        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = flit(row, k);
    endtask

    rr_vec_t exp_rot;
    rr_vec_t prio_m;
    int      wins [N];
    int      pkts;
    logic [DW-1:0] exp_d;

    initial begin
        total = 0;
        bad   = 0;
        // per-cycle vectors: prio, valid, tail, out_ready | grant, out_valid, ready, change_order
        tbl[0]  = '{4'b0100, 4'b1011, 4'b1011, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0100, 4'b1011, 4'b1011, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1};
        tbl[2]  = '{4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0001, 4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0001, 4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b0};
        tbl[5]  = '{4'b0001, 4'b0101, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0};
        tbl[6]  = '{4'b0001, 4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b0};
        tbl[7]  = '{4'b0001, 4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1};
        tbl[8]  = '{4'b0010, 4'b1010, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0010, 4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0};
        tbl[10] = '{4'b0010, 4'b1000, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0010, 1'b0};
        tbl[11] = '{4'b0010, 4'b1000, 4'b1000, 1'b1, 4'b0010, 1'b0, 4'b0010, 1'b0};
        tbl[12] = '{4'b0010, 4'b1010, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1};
        tbl[13] = '{4'b0100, 4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[14] = '{4'b0100, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1};
        tbl[15] = '{4'b0000, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[16] = '{4'b0000, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1};
        tbl[17] = '{4'b0110, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[18] = '{4'b0110, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1};
        tbl[19] = '{4'b1000, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[20] = '{4'b1000, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1};
        tbl[21] = '{4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};

        reset          = 1'b0;
        priority_order = 4'b0001;
        req_valid      = 4'b1111;
        req_tail       = 4'b1111;
        req_data       = '0;
        out_ready      = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", -1, 32'(grant), 32'h0);
        chk("rst_ovalid", -1, 32'(out_valid), 32'h0);
        chk("rst_ready", -1, 32'(req_ready), 32'h0);
        chk("rst_data", -1, out_data, 32'h0);
        chk("rst_co", -1, 32'(change_order), 32'h0);
        req_valid = 4'b0000;
        req_tail  = 4'b0000;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            priority_order = tbl[i].prio;
            req_valid      = tbl[i].vld;
            req_tail       = tbl[i].tail;
            out_ready      = tbl[i].ordy;
            drive_data(i);
            #1;
            chk("grant", i, 32'(grant), 32'(tbl[i].e_gnt));
            chk("out_valid", i, 32'(out_valid), 32'(tbl[i].e_ov));
            chk("req_ready", i, 32'(req_ready), 32'(tbl[i].e_rdy));
            chk("change_order", i, 32'(change_order), 32'(tbl[i].e_co));
            exp_d = tbl[i].e_ov ? flit(i, idx_of(tbl[i].e_gnt)) : 32'h0;
            chk("out_data", i, out_data, exp_d);
            if (tbl[i].e_ov) chk("out_tail", i, 32'(out_tail), 32'(tbl[i].tail[idx_of(tbl[i].e_gnt)]));
        end

        // Reset asserted on flit 2 of a 4-flit packet from port 0.
        @(negedge clk);
        priority_order = 4'b0001;
        req_valid      = 4'b0001;
        req_tail       = 4'b0000;
        out_ready      = 1'b1;
        drive_data(40);
        #1 chk("mid_arb", 40, 32'(grant), 32'h0);
        @(negedge clk);
        #1 chk("mid_flit1", 41, 32'(out_valid), 32'h1);
        @(negedge clk);
        #1 chk("mid_flit2", 42, 32'(grant), 32'h1);
        req_tail = 4'b0001;
        reset    = 1'b0;
        #1;
        chk("mid_rst_grant", 42, 32'(grant), 32'h0);
        chk("mid_rst_ovalid", 42, 32'(out_valid), 32'h0);
        chk("mid_rst_ready", 42, 32'(req_ready), 32'h0);
        chk("mid_rst_data", 42, out_data, 32'h0);
        chk("mid_rst_tail", 42, 32'(out_tail), 32'h0);
        chk("mid_rst_co", 42, 32'(change_order), 32'h0);
        @(negedge clk);
        reset          = 1'b1;
        priority_order = 4'b0100;
        req_valid      = 4'b0101;
        req_tail       = 4'b0100;
        #1 chk("post_rst_idle", 43, 32'(grant), 32'h0);
        @(negedge clk);
        #1;
        chk("post_rst_grant", 44, 32'(grant), 32'h4);
        chk("post_rst_co", 44, 32'(change_order), 32'h1);
        chk("post_rst_data", 44, out_data, flit(40, 2));
        @(negedge clk);
        req_valid = 4'b0000;
        #1 chk("post_rst_done", 45, 32'(grant), 32'h0);

        // Closed loop with a modelled rotating priority register starting at 4'b0100.
        prio_m  = 4'b0100;
        exp_rot = 4'b0100;
        pkts    = 0;
        for (int k = 0; k < N; k++) wins[k] = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            priority_order = prio_m;
            req_valid      = 4'b1111;
            req_tail       = 4'b1111;
            out_ready      = 1'b1;
            #1;
            if (grant != 4'b0000) begin
                chk("loop_grant", 60 + c, 32'(grant), 32'(exp_rot));
                chk("loop_co", 60 + c, 32'(change_order), 32'h1);
                wins[idx_of(grant)]++;
                pkts++;
                exp_rot = {exp_rot[N-2:0], exp_rot[N-1]};
            end
            if (change_order) prio_m = {prio_m[N-2:0], prio_m[N-1]};
        end
        chk("loop_packets", 80, 32'(pkts), 32'd8);
        for (int k = 0; k < N; k++) chk("loop_share", 81 + k, 32'(wins[k]), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
